// File: rtl/pooling_controller.sv
// Buffers a MAP_W x MAP_W feature map, then issues each 2x2 window to an external
// pooling unit one at a time and forwards each pooled result with its window index.
module pooling_controller #(
  parameter int DATA_W = 22,
  parameter int MAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] pixelIn,
  input  logic              pixelValid,
  output logic              pixelReady,
  output logic [DATA_W-1:0] poolIn1,
  output logic [DATA_W-1:0] poolIn2,
  output logic [DATA_W-1:0] poolIn3,
  output logic [DATA_W-1:0] poolIn4,
  output logic              poolEnable,
  input  logic [DATA_W-1:0] poolOut,
  input  logic              poolDone,
  output logic [DATA_W-1:0] resultOut,
  output logic [7:0]        resultIdx,
  output logic              resultValid,
  output logic              busy,
  output logic              frameDone
);

  localparam int NPIX = MAP_W * MAP_W;
  localparam int HALF = MAP_W / 2;
  localparam int NWIN = HALF * HALF;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic [AW-1:0]     load_cnt;
  logic [7:0]        win_cnt;
  logic [7:0]        issue_k;
  logic              pix_xfer;
  logic              last_pix;
  logic              last_win;
  logic [DATA_W-1:0] buf_mem [NPIX];
  logic [AW-1:0]     win_addr [4];
  logic [DATA_W-1:0] win_pix [4];

  // Buffer address of element (dr,dc) inside 2x2 window k.
  function automatic logic [AW-1:0] pix_addr(input logic [7:0] k, input int dr, input int dc);
    int r;
    int c;
    r = int'(k) / HALF;
    c = int'(k) % HALF;
    return AW'((2 * r + dr) * MAP_W + 2 * c + dc);
  endfunction

  assign pix_xfer = pixelReady && pixelValid;
  assign last_pix = (load_cnt == AW'(NPIX - 1));
  assign last_win = (win_cnt == 8'(NWIN - 1));
  assign issue_k  = (state == WAIT) ? win_cnt + 8'd1 : 8'd0;

  // The final pixel can belong to window 0 (MAP_W=2), so forward it around the buffer.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      win_addr[i] = pix_addr(issue_k, i / 2, i % 2);
      win_pix[i]  = (pix_xfer && (win_addr[i] == load_cnt)) ? pixelIn : buf_mem[win_addr[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (pix_xfer) buf_mem[load_cnt] <= pixelIn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      load_cnt    <= '0;
      win_cnt     <= '0;
      pixelReady  <= 1'b0;
      poolEnable  <= 1'b0;
      resultValid <= 1'b0;
      busy        <= 1'b0;
      frameDone   <= 1'b0;
      poolIn1     <= '0;
      poolIn2     <= '0;
      poolIn3     <= '0;
      poolIn4     <= '0;
      resultOut   <= '0;
      resultIdx   <= '0;
    end else begin
      poolEnable  <= 1'b0;
      resultValid <= 1'b0;
      frameDone   <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        load_cnt   <= '0;
        win_cnt    <= '0;
        pixelReady <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state      <= LOAD;
            load_cnt   <= '0;
            win_cnt    <= '0;
            pixelReady <= 1'b1;
            busy       <= 1'b1;
          end
          LOAD: if (pix_xfer) begin
            if (last_pix) begin
              state      <= ISSUE;
              pixelReady <= 1'b0;
              load_cnt   <= '0;
              win_cnt    <= '0;
              poolEnable <= 1'b1;
              poolIn1    <= win_pix[0];
              poolIn2    <= win_pix[1];
              poolIn3    <= win_pix[2];
              poolIn4    <= win_pix[3];
            end else begin
              load_cnt <= load_cnt + AW'(1);
            end
          end
          ISSUE: state <= WAIT;
          WAIT: if (poolDone) begin
            resultOut   <= poolOut;
            resultIdx   <= win_cnt;
            resultValid <= 1'b1;
            if (last_win) begin
              state     <= DONE;
              frameDone <= 1'b1;
            end else begin
              state      <= ISSUE;
              win_cnt    <= win_cnt + 8'd1;
              poolEnable <= 1'b1;
              poolIn1    <= win_pix[0];
              poolIn2    <= win_pix[1];
              poolIn3    <= win_pix[2];
              poolIn4    <= win_pix[3];
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            pixelReady <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pooling_controller.sv
// Directed bench for pooling_controller (MAP_W=4, DATA_W=22) with a 2-cycle pooling-unit model.
module tb_pooling_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [21:0] pixelIn = '0;
  logic        pixelValid = 1'b0;
  logic        pixelReady;
  logic [21:0] poolIn1, poolIn2, poolIn3, poolIn4;
  logic        poolEnable;
  logic [21:0] poolOut;
  logic        poolDone;
  logic [21:0] resultOut;
  logic [7:0]  resultIdx;
  logic        resultValid;
  logic        busy;
  logic        frameDone;

  pooling_controller #(.DATA_W(22), .MAP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pixelIn(pixelIn), .pixelValid(pixelValid), .pixelReady(pixelReady),
    .poolIn1(poolIn1), .poolIn2(poolIn2), .poolIn3(poolIn3), .poolIn4(poolIn4),
    .poolEnable(poolEnable), .poolOut(poolOut), .poolDone(poolDone),
    .resultOut(resultOut), .resultIdx(resultIdx), .resultValid(resultValid),
    .busy(busy), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  // Pooling-unit model: result two cycles after the enable strobe.
  logic        mode_first = 1'b0;
  logic        spur = 1'b0;
  logic [1:0]  pm_cnt = '0;
  logic [21:0] pm_val = '0;

  function automatic logic [21:0] max4(input logic [21:0] a, b, c, d);
    logic [21:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  always @(posedge clk) begin
    if (poolEnable) begin
      pm_cnt <= 2'd2;
      pm_val <= mode_first ? poolIn1 : max4(poolIn1, poolIn2, poolIn3, poolIn4);
    end else if (pm_cnt != 2'd0) begin
      pm_cnt <= pm_cnt - 2'd1;
    end
  end
  assign poolDone = (pm_cnt == 2'd1) | spur;
  assign poolOut  = pm_val;

  // Monitor of strobes and transfers.
  logic        mon_clr = 1'b0;
  int          cyc = 0;
  int          n_en = 0, n_rv = 0, n_fd = 0;
  int          first_en_cyc = 0, last_xfer_cyc = 0;
  logic        fd_with_rv = 1'b0;
  logic [87:0] en_win [8];
  logic [21:0] rv_val [8];
  logic [7:0]  rv_idx [8];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      n_en <= 0;
      n_rv <= 0;
      n_fd <= 0;
    end else begin
      if (pixelValid && pixelReady) last_xfer_cyc <= cyc;
      if (poolEnable) begin
        en_win[n_en[2:0]] <= {poolIn1, poolIn2, poolIn3, poolIn4};
        if (n_en == 0) first_en_cyc <= cyc;
        n_en <= n_en + 1;
      end
      if (resultValid) begin
        rv_val[n_rv[2:0]] <= resultOut;
        rv_idx[n_rv[2:0]] <= resultIdx;
        n_rv <= n_rv + 1;
      end
      if (frameDone) begin
        n_fd <= n_fd + 1;
        fd_with_rv <= resultValid;
      end
    end
  end

  int n_assert = 0;
  int n_fail = 0;
  logic [21:0] pix [16];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_pixels(input int npix, input bit gap);
    int i = 0;
    int guard = 0;
    logic acc;
    bit tog = 1'b0;
    while (i < npix && guard < 200) begin
      pixelIn = pix[i];
      pixelValid = gap ? tog : 1'b1;
      tog = ~tog;
      acc = pixelValid && pixelReady;
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    pixelValid = 1'b0;
    chk("load_complete", 128'(i), 128'(npix));
  endtask

  task automatic wait_frame();
    int fd0 = n_fd;
    for (int k = 0; k < 200 && n_fd == fd0; k++) @(negedge clk);
    chk("frame_done_seen", 128'(n_fd != fd0), 128'(1));
  endtask

  task automatic check_std_frame(input string tag);
    chk({tag, "_n_en"}, 128'(n_en), 128'(4));
    chk({tag, "_win0"}, en_win[0], {22'd0, 22'd1, 22'd4, 22'd5});
    chk({tag, "_win1"}, en_win[1], {22'd2, 22'd3, 22'd6, 22'd7});
    chk({tag, "_win2"}, en_win[2], {22'd8, 22'd9, 22'd12, 22'd13});
    chk({tag, "_win3"}, en_win[3], {22'd10, 22'd11, 22'd14, 22'd15});
    chk({tag, "_n_rv"}, 128'(n_rv), 128'(4));
    chk({tag, "_res0"}, {rv_idx[0], rv_val[0]}, {8'd0, 22'd5});
    chk({tag, "_res1"}, {rv_idx[1], rv_val[1]}, {8'd1, 22'd7});
    chk({tag, "_res2"}, {rv_idx[2], rv_val[2]}, {8'd2, 22'd13});
    chk({tag, "_res3"}, {rv_idx[3], rv_val[3]}, {8'd3, 22'd15});
    chk({tag, "_n_fd"}, 128'(n_fd), 128'(1));
    chk({tag, "_fd_with_rv"}, 128'(fd_with_rv), 128'(1));
    chk({tag, "_busy_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_outputs", {pixelReady, poolEnable, resultValid, busy, frameDone},  5'b0);
    chk("rst_data", {poolIn1, poolIn2, poolIn3, poolIn4, resultOut, resultIdx}, 140'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ascending map, max pooling
    for (int i = 0; i < 16; i++) pix[i] = 22'(i);
    clr_mon();
    pulse_start();
    chk("load_ready", 128'(pixelReady), 128'(1));
    chk("load_busy", 128'(busy), 128'(1));
    load_pixels(16, 1'b0);
    wait_frame();
    check_std_frame("max");

    // Signed map, pool returns first element
    pix = '{22'h380C8, 22'h3FFFE4, 22'h000001, 22'h200000,
            22'h1FFFFF, 22'h3FFFFF, 22'h0ABCDE, 22'h155555,
            22'h2AAAAA, 22'h000010, 22'h3C0C0C, 22'h012345,
            22'h3FFFE4, 22'h222222, 22'h3000FF, 22'h100001};
    mode_first = 1'b1;
    clr_mon();
    pulse_start();
    load_pixels(16, 1'b0);
    wait_frame();
    chk("sgn_win0", en_win[0], {22'h380C8, 22'h3FFFE4, 22'h1FFFFF, 22'h3FFFFF});
    chk("sgn_res0", {rv_idx[0], rv_val[0]}, {8'd0, 22'h380C8});
    chk("sgn_res1", {rv_idx[1], rv_val[1]}, {8'd1, 22'h000001});
    chk("sgn_res2", {rv_idx[2], rv_val[2]}, {8'd2, 22'h2AAAAA});
    chk("sgn_res3", {rv_idx[3], rv_val[3]}, {8'd3, 22'h3C0C0C});
    mode_first = 1'b0;

    // Gapped pixelValid
    for (int i = 0; i < 16; i++) pix[i] = 22'(i);
    clr_mon();
    pulse_start();
    load_pixels(16, 1'b1);
    wait_frame();
    check_std_frame("gap");
    chk("gap_first_en_latency", 128'(first_en_cyc - last_xfer_cyc), 128'(1));

    // Abort during second WAIT
    clr_mon();
    pulse_start();
    load_pixels(16, 1'b0);
    for (int k = 0; k < 100 && n_en < 2; k++) @(negedge clk);
    chk("abort_reached_win1", 128'(n_en), 128'(2));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    repeat (10) @(negedge clk);
    chk("abort_n_rv", 128'(n_rv), 128'(1));
    chk("abort_n_fd", 128'(n_fd), 128'(0));
    chk("abort_n_en", 128'(n_en), 128'(2));
    clr_mon();
    pulse_start();
    load_pixels(16, 1'b0);
    wait_frame();
    check_std_frame("post_abort");

    // Reset during LOAD after 7 pixels
    clr_mon();
    pulse_start();
    load_pixels(7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_ctrl", {pixelReady, poolEnable, resultValid, busy, frameDone}, 5'b0);
    chk("mrst_data", {poolIn1, poolIn4, resultOut, resultIdx}, 74'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_ready_low", 128'(pixelReady), 128'(0));
    chk("mrst_no_strobes", 128'(n_en + n_rv + n_fd), 128'(0));

    // Spurious poolDone in IDLE and LOAD, start held during WAIT
    clr_mon();
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    chk("spur_idle_busy", 128'(busy), 128'(0));
    chk("spur_idle_strobes", 128'(n_rv + n_fd), 128'(0));
    pulse_start();
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    chk("spur_load_ready", 128'(pixelReady), 128'(1));
    chk("spur_load_strobes", 128'(n_en + n_rv + n_fd), 128'(0));
    for (int i = 0; i < 16; i++) pix[i] = 22'(i);
    load_pixels(16, 1'b0);
    for (int k = 0; k < 100 && n_en < 1; k++) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_frame();
    check_std_frame("hold_start");
    repeat (4) @(negedge clk);
    chk("hold_start_no_restart", 128'(busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
